// File: rtl/operand_fifo_reader_if.sv
// Operand FIFO pair / multiplier / result FIFO signal bundle for operand_fifo_reader.
// master = controller side, slave = FIFOs + multiplier side.
interface operand_fifo_reader_if #(
  parameter int DATA = 256
);
  logic            a_empty;
  logic            b_empty;
  logic            a_rd_en;
  logic            b_rd_en;
  logic [DATA-1:0] a_data;
  logic [DATA-1:0] b_data;
  logic            mul_start;
  logic [DATA-1:0] mul_op_a;
  logic [DATA-1:0] mul_op_b;
  logic            mul_done;
  logic [DATA-1:0] mul_result;
  logic            res_full;
  logic            res_wr_en;
  logic [DATA-1:0] res_data;
  logic            busy;
  logic [15:0]     pair_count;

  modport master (
    input  a_empty, b_empty, a_data, b_data, mul_done, mul_result, res_full,
    output a_rd_en, b_rd_en, mul_start, mul_op_a, mul_op_b, res_wr_en, res_data,
           busy, pair_count
  );

  modport slave (
    output a_empty, b_empty, a_data, b_data, mul_done, mul_result, res_full,
    input  a_rd_en, b_rd_en, mul_start, mul_op_a, mul_op_b, res_wr_en, res_data,
           busy, pair_count
  );
endinterface

// File: rtl/operand_fifo_reader.sv
// Pops an A/B operand pair, runs one multiply, pushes the product to the result FIFO.
// Latency: 3 cycles from both-non-empty to mul_start; 6-cycle minimum loop with a 1-cycle multiplier.
// Backpressure: holds in WRITE with res_wr_en low while res_full is set; no new pop meanwhile.
module operand_fifo_reader #(
  parameter int DATA = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_fifo_reader_if.master m
);
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_CAPTURE, S_START, S_WAIT, S_WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [DATA-1:0] op_a_q, op_b_q, res_q;
  logic [15:0]     cnt_q;
  logic            wr_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!m.a_empty && !m.b_empty) state_d = S_POP;
      S_POP:     state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (m.mul_done) state_d = S_WRITE;
      S_WRITE:   if (!m.res_full) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Everything but res_wr_en is a pure state decode.
  always_comb begin
    m.a_rd_en   = (state_q == S_POP);
    m.b_rd_en   = (state_q == S_POP);
    m.mul_start = (state_q == S_START);
    m.busy      = (state_q != S_IDLE);
    wr_fire     = (state_q == S_WRITE) && !m.res_full;
    m.res_wr_en = wr_fire;
  end

  // FIFO Data_out is registered, so the popped pair is only valid in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == S_CAPTURE) begin
        op_a_q <= m.a_data;
        op_b_q <= m.b_data;
      end
      if (state_q == S_WAIT && m.mul_done) res_q <= m.mul_result;
      if (wr_fire) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign m.mul_op_a   = op_a_q;
  assign m.mul_op_b   = op_b_q;
  assign m.res_data   = res_q;
  assign m.pair_count = cnt_q;
endmodule

// File: tb/tb_operand_fifo_reader.sv
// Directed bench for operand_fifo_reader: FIFO/multiplier responders plus a scoreboard monitor.
module tb_operand_fifo_reader;
  localparam int DATA = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fifo_reader_if #(.DATA(DATA)) bus();
  operand_fifo_reader #(.DATA(DATA)) dut (.clk(clk), .rst_n(rst_n), .m(bus));

  logic [DATA-1:0] fa[$], fb[$];
  logic [DATA-1:0] exp_a[$], exp_b[$], exp_res[$];
  int checks = 0, passed = 0;
  int wr_cnt = 0, rda_cnt = 0, rdb_cnt = 0;
  int mul_lat = 1, mul_cd = 0;

  task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void upd_flags();
    bus.a_empty = (fa.size() == 0);
    bus.b_empty = (fb.size() == 0);
  endfunction

  task automatic push_pair(input logic [DATA-1:0] a, input logic [DATA-1:0] b,
                           input logic [DATA-1:0] prod, input bit expect_wr);
    fa.push_back(a);
    fb.push_back(b);
    exp_a.push_back(a);
    exp_b.push_back(b);
    if (expect_wr) exp_res.push_back(prod);
    upd_flags();
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    check("writes_done", DATA'(wr_cnt), DATA'(target));
    @(negedge clk); #2;
  endtask

  // FIFO and multiplier responders; inputs change on the falling edge only.
  initial begin
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (mul_cd > 0) begin
        mul_cd--;
        if (mul_cd == 0) begin
          bus.mul_done   = 1'b1;
          bus.mul_result = bus.mul_op_a * bus.mul_op_b;
        end
      end
      if (bus.mul_start) mul_cd = mul_lat;
      if (bus.a_rd_en && fa.size() > 0) bus.a_data = fa.pop_front();
      if (bus.b_rd_en && fb.size() > 0) bus.b_data = fb.pop_front();
      upd_flags();
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (bus.mul_start) begin
        if (exp_a.size() == 0) check("start_with_no_pending", DATA'(bus.mul_start), '0);
        else begin
          check("mul_op_a", bus.mul_op_a, exp_a.pop_front());
          check("mul_op_b", bus.mul_op_b, exp_b.pop_front());
        end
      end
      if (bus.res_wr_en) begin
        wr_cnt++;
        if (exp_res.size() == 0) check("write_with_no_pending", DATA'(bus.res_wr_en), '0);
        else check("res_data", bus.res_data, exp_res.pop_front());
      end
      if (bus.a_rd_en) rda_cnt++;
      if (bus.b_rd_en) rdb_cnt++;
      if (bus.a_rd_en != bus.b_rd_en) check("rd_en_pair", DATA'(bus.b_rd_en), DATA'(bus.a_rd_en));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] act;
    logic       busy_all;
    logic [DATA-1:0] ones;
    int base, ra, rb;
    ones = '1;

    bus.res_full   = 1'b0;
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    bus.a_data     = '0;
    bus.b_data     = '0;
    upd_flags();

    // Reset values
    #12;
    check("rst_busy", DATA'(bus.busy), '0);
    check("rst_pair_count", DATA'(bus.pair_count), '0);
    check("rst_enables", DATA'({bus.a_rd_en, bus.b_rd_en, bus.mul_start, bus.res_wr_en}), '0);
    check("rst_ops", bus.mul_op_a | bus.mul_op_b, '0);
    check("rst_res_data", bus.res_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both FIFOs empty: nothing happens
    act = '0;
    repeat (20) begin
      @(negedge clk); #1;
      act |= {bus.busy, bus.a_rd_en, bus.b_rd_en, bus.mul_start, bus.res_wr_en};
    end
    check("idle_activity", DATA'(act), '0);
    check("idle_pair_count", DATA'(bus.pair_count), '0);

    // A alone never popped; then pair (1,2) with start 3 cycles later
    base = wr_cnt;
    @(negedge clk);
    fa.push_back(256'h1);
    exp_a.push_back(256'h1);
    upd_flags();
    act = '0;
    repeat (5) begin
      @(negedge clk); #1;
      act |= {2'b00, bus.a_rd_en, bus.b_rd_en, bus.busy};
    end
    check("no_lone_pop", DATA'(act), '0);
    @(negedge clk);
    fb.push_back(256'h2);
    exp_b.push_back(256'h2);
    exp_res.push_back(256'h2);
    upd_flags();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("start_cycle_%0d", i), DATA'(bus.mul_start), DATA'(i == 3));
    end
    wait_writes(base + 1, 50);
    check("count_after_first", DATA'(bus.pair_count), DATA'(1));

    // Three queued pairs, multiplier latency 4
    mul_lat = 4;
    base = wr_cnt; ra = rda_cnt; rb = rdb_cnt;
    @(negedge clk);
    push_pair(256'h3, 256'h4, 256'hC, 1'b1);
    push_pair(ones, 256'h2, ~256'h1, 1'b1);
    push_pair(256'h1 << 200, 256'h1 << 60, 256'h0, 1'b1);
    wait_writes(base + 3, 200);
    check("count_after_three", DATA'(bus.pair_count), DATA'(4));
    check("a_pops_three", DATA'(rda_cnt - ra), DATA'(3));
    check("b_pops_three", DATA'(rdb_cnt - rb), DATA'(3));

    // Result FIFO full for 7 WRITE cycles
    mul_lat = 1;
    base = wr_cnt; ra = rda_cnt;
    @(negedge clk);
    bus.res_full = 1'b1;
    push_pair(256'hDEAD, 256'h1, 256'hDEAD, 1'b1);
    repeat (5) @(negedge clk);
    push_pair(256'h5, 256'h6, 256'h1E, 1'b1);
    act = '0;
    busy_all = 1'b1;
    repeat (7) begin
      #1;
      act |= {2'b00, bus.res_wr_en, bus.a_rd_en, bus.b_rd_en};
      busy_all &= bus.busy;
      @(negedge clk);
    end
    check("hold_quiet", DATA'(act), '0);
    check("hold_busy", DATA'(busy_all), DATA'(1));
    check("hold_a_pops", DATA'(rda_cnt - ra), DATA'(1));
    bus.res_full = 1'b0;
    #1;
    check("write_after_release", DATA'(bus.res_wr_en), DATA'(1));
    wait_writes(base + 2, 100);
    check("count_after_hold", DATA'(bus.pair_count), DATA'(6));

    // Reset while waiting on the multiplier
    mul_lat = 20;
    @(negedge clk);
    push_pair(256'h9, 256'h9, 256'h51, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("start_before_reset", DATA'(bus.mul_start), DATA'(1));
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", DATA'(bus.busy), '0);
    check("async_count", DATA'(bus.pair_count), '0);
    check("async_ops", bus.mul_op_a | bus.mul_op_b, '0);
    check("async_res_data", bus.res_data, '0);
    check("async_enables", DATA'({bus.a_rd_en, bus.b_rd_en, bus.mul_start, bus.res_wr_en}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_cnt;
    act = '0;
    repeat (30) begin
      @(negedge clk); #1;
      act |= {3'b000, bus.res_wr_en, bus.busy};
    end
    check("late_done_ignored", DATA'(act), '0);
    check("late_done_no_write", DATA'(wr_cnt), DATA'(base));

    // pair_count wrap
    mul_lat = 1;
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    check("count_preload", DATA'(bus.pair_count), DATA'(16'hFFFF));
    base = wr_cnt;
    push_pair(256'h7, 256'h3, 256'h15, 1'b1);
    wait_writes(base + 1, 50);
    check("count_wrap", DATA'(bus.pair_count), '0);

    check("pending_results", DATA'(exp_res.size()), '0);
    check("pending_starts", DATA'(exp_a.size()), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
